// File: rtl/sr_icache.sv
// sr_icache: direct-mapped instruction cache with a single-line refill engine.
// The CPU side uses word addresses. A hit returns one word per cycle from the
// LOOKUP state. A miss issues one line-refill request and collects 2^OFFSET_W
// beats from memory, which arrive in offset order.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no outstanding fetch; waiting for im_req
// LOOKUP | req_addr is being compared against the tag/valid arrays
// REFILL | line request issued; collecting beats into data[index]
module sr_icache #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic [31:0] im_data,
  output logic        im_drdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         reqAddr;
  logic [OFFSET_W-1:0] beatCnt;
  logic                discard;
  logic                firstAfterRefill;
  logic [LINES-1:0]    validBits;

  // Tag and data storage are not reset; validBits alone decides whether a
  // line may be used.
  logic [TAG_W-1:0]    tagMem  [LINES];
  logic [31:0]         dataMem [LINES*WORDS];

  logic [OFFSET_W-1:0] reqOffset;
  logic [INDEX_W-1:0]  reqIndex;
  logic [TAG_W-1:0]    reqTag;
  logic                lookupHit;
  logic                refillBeat;
  logic                lastBeat;

  assign reqOffset  = reqAddr[OFFSET_W-1:0];
  assign reqIndex   = reqAddr[OFFSET_W +: INDEX_W];
  assign reqTag     = reqAddr[31:INDEX_W+OFFSET_W];

  assign lookupHit  = (state == LOOKUP) && validBits[reqIndex] &&
                      (tagMem[reqIndex] == reqTag);
  assign refillBeat = (state == REFILL) && mem_rvalid;
  assign lastBeat   = refillBeat && (beatCnt == {OFFSET_W{1'b1}});

  // The hit word is driven in the LOOKUP cycle itself. This gives the
  // one-cycle hit latency and one word per cycle when hits stream back to back.
  // The output is zero whenever no word is being delivered.
  assign im_drdy = lookupHit;
  assign im_data = lookupHit ? dataMem[{reqIndex, reqOffset}] : 32'd0;

  // Refill storage: each accepted beat goes to its offset slot, and the tag is
  // committed together with the last beat.
  always_ff @(posedge clk) begin
    if (refillBeat) begin
      dataMem[{reqIndex, beatCnt}] <= mem_rdata;
    end
    if (lastBeat) begin
      tagMem[reqIndex] <= reqTag;
    end
  end

  // Control FSM together with the valid bits, the refill request and the
  // performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      reqAddr          <= 32'd0;
      beatCnt          <= '0;
      discard          <= 1'b0;
      firstAfterRefill <= 1'b0;
      validBits        <= '0;
      mem_req          <= 1'b0;
      mem_addr         <= 32'd0;
      hit_cnt          <= 32'd0;
      miss_cnt         <= 32'd0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (im_req) begin
            reqAddr <= im_addr;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          firstAfterRefill <= 1'b0;
          if (lookupHit) begin
            // The lookup that completes a refill is not counted as a hit.
            if (!firstAfterRefill) begin
              hit_cnt <= hit_cnt + 32'd1;
            end
            if (im_req) begin
              reqAddr <= im_addr;
            end else begin
              state <= IDLE;
            end
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {reqAddr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            miss_cnt <= miss_cnt + 32'd1;
            beatCnt  <= '0;
            discard  <= 1'b0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          // A flush seen while the line is still arriving marks the line as
          // stale, so it is never marked valid.
          if (flush) begin
            discard <= 1'b1;
          end
          if (mem_rvalid) begin
            beatCnt <= beatCnt + 1'b1;
            if (lastBeat) begin
              if (!discard) begin
                validBits[reqIndex] <= 1'b1;
              end
              discard          <= 1'b0;
              beatCnt          <= '0;
              firstAfterRefill <= 1'b1;
              state            <= LOOKUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // This assignment comes last so that flush wins over a valid-set on the
      // same edge.
      if (flush) begin
        validBits <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sr_icache.sv
// tb_sr_icache: directed bench for sr_icache. A vector table covers plain
// hits and misses. Hand-written sequences cover streaming hits, flush during a
// refill, and reset during a refill.
module tb_sr_icache;

  logic        clk;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        im_drdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int passes = 0;
  bit early;

  typedef struct {
    logic [31:0] addr;
    bit          isHit;
    logic [31:0] fill;
    int          gap;
    logic [31:0] expData;
    logic [31:0] expLine;
    logic [31:0] expHit;
    logic [31:0] expMiss;
  } vec_t;

  vec_t tbl[10];

  sr_icache #(.INDEX_W(4), .OFFSET_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr),
    .im_data(im_data), .im_drdy(im_drdy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "watchdog timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input bit h, input logic [31:0] f,
                              input int g, input logic [31:0] d, input logic [31:0] l,
                              input logic [31:0] eh, input logic [31:0] em);
    vec_t v;
    v.addr = a; v.isHit = h; v.fill = f; v.gap = g;
    v.expData = d; v.expLine = l; v.expHit = eh; v.expMiss = em;
    return v;
  endfunction

  task automatic waitMemReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Four beats, each preceded by `gap` idle cycles. flushBeat < 0 means no
  // flush is issued.
  task automatic deliver(input logic [31:0] fill, input int gap, input int flushBeat);
    bit first;
    first = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (im_drdy) early = 1'b1;
        if (first) begin chk("memReqPulseWidth", {31'd0, mem_req}, 32'd0); first = 1'b0; end
      end
      mem_rvalid = 1'b1;
      mem_rdata  = fill + b;
      flush      = (b == flushBeat);
      @(negedge clk);
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      if (b < 3 && im_drdy) early = 1'b1;
      if (first) begin chk("memReqPulseWidth", {31'd0, mem_req}, 32'd0); first = 1'b0; end
    end
  endtask

  task automatic runVec(input vec_t v);
    bit ok;
    @(negedge clk);
    im_req = 1'b1; im_addr = v.addr;
    @(negedge clk);
    im_req = 1'b0;
    if (v.isHit) begin
      chk("hitDrdy", {31'd0, im_drdy}, 32'd1);
      chk("hitData", im_data, v.expData);
    end else begin
      chk("missDrdyLow", {31'd0, im_drdy}, 32'd0);
      chk("missDataZero", im_data, 32'd0);
      waitMemReq(ok);
      chk("memReqSeen", {31'd0, ok}, 32'd1);
      chk("memAddr", mem_addr, v.expLine);
      early = 1'b0;
      deliver(v.fill, v.gap, -1);
      chk("noEarlyDrdy", {31'd0, early}, 32'd0);
      chk("refillDrdy", {31'd0, im_drdy}, 32'd1);
      chk("refillData", im_data, v.expData);
    end
    @(negedge clk);
    chk("idleDrdyLow", {31'd0, im_drdy}, 32'd0);
    chk("hitCnt", hit_cnt, v.expHit);
    chk("missCnt", miss_cnt, v.expMiss);
    if (!v.isHit) chk("memAddrHeld", mem_addr, v.expLine);
  endtask

  // A miss whose refill is hit by a flush on beat flushBeat. The line must stay
  // invalid, so the following lookup refills it again.
  task automatic missFlush(input logic [31:0] a, input logic [31:0] line, input int flushBeat,
                           input logic [31:0] fill1, input logic [31:0] fill2,
                           input logic [31:0] expData, input logic [31:0] expHit,
                           input logic [31:0] expMiss);
    bit ok;
    @(negedge clk);
    im_req = 1'b1; im_addr = a;
    @(negedge clk);
    im_req = 1'b0;
    waitMemReq(ok);
    chk("flushFirstReq", {31'd0, ok}, 32'd1);
    chk("flushFirstAddr", mem_addr, line);
    deliver(fill1, 0, flushBeat);
    chk("discardDrdyLow", {31'd0, im_drdy}, 32'd0);
    waitMemReq(ok);
    chk("flushSecondReq", {31'd0, ok}, 32'd1);
    chk("flushSecondAddr", mem_addr, line);
    deliver(fill2, 0, -1);
    chk("reRefillDrdy", {31'd0, im_drdy}, 32'd1);
    chk("reRefillData", im_data, expData);
    @(negedge clk);
    chk("flushHitCnt", hit_cnt, expHit);
    chk("flushMissCnt", miss_cnt, expMiss);
  endtask

  initial begin
    bit ok;
    tbl[0] = mk(32'h0000_0002, 1, 32'h0,  0, 32'hA2, 32'h0,         32'd4, 32'd1);
    tbl[1] = mk(32'h0000_0040, 0, 32'hB0, 1, 32'hB0, 32'h40,        32'd4, 32'd2);
    tbl[2] = mk(32'h0000_0043, 1, 32'h0,  0, 32'hB3, 32'h0,         32'd5, 32'd2);
    tbl[3] = mk(32'h0000_0001, 0, 32'hC0, 0, 32'hC1, 32'h0,         32'd5, 32'd3);
    tbl[4] = mk(32'h0000_0015, 0, 32'hD0, 3, 32'hD1, 32'h14,        32'd5, 32'd4);
    tbl[5] = mk(32'h0000_0017, 1, 32'h0,  0, 32'hD3, 32'h0,         32'd6, 32'd4);
    tbl[6] = mk(32'h0000_0002, 1, 32'h0,  0, 32'hC2, 32'h0,         32'd7, 32'd4);
    tbl[7] = mk(32'hFFFF_FFFF, 0, 32'hE0, 2, 32'hE3, 32'hFFFF_FFFC, 32'd7, 32'd5);
    tbl[8] = mk(32'hFFFF_FFFC, 1, 32'h0,  0, 32'hE0, 32'h0,         32'd8, 32'd5);
    tbl[9] = mk(32'h0000_003C, 0, 32'hF0, 0, 32'hF0, 32'h3C,        32'd8, 32'd6);

    rst_n = 1'b0; im_req = 1'b0; im_addr = 32'd0;
    mem_rdata = 32'd0; mem_rvalid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstDrdy", {31'd0, im_drdy}, 32'd0);
    chk("rstData", im_data, 32'd0);
    chk("rstMemReq", {31'd0, mem_req}, 32'd0);
    chk("rstMemAddr", mem_addr, 32'd0);
    chk("rstHitCnt", hit_cnt, 32'd0);
    chk("rstMissCnt", miss_cnt, 32'd0);
    rst_n = 1'b1;

    // Cold miss on address 0.
    runVec(mk(32'h0, 0, 32'hA0, 0, 32'hA0, 32'h0, 32'd0, 32'd1));

    // Streaming hits: addresses 1, 2, 3 on consecutive cycles.
    @(negedge clk);
    im_req = 1'b1; im_addr = 32'd1;
    @(negedge clk);
    chk("streamDrdy1", {31'd0, im_drdy}, 32'd1);
    chk("streamData1", im_data, 32'hA1);
    im_addr = 32'd2;
    @(negedge clk);
    chk("streamDrdy2", {31'd0, im_drdy}, 32'd1);
    chk("streamData2", im_data, 32'hA2);
    im_addr = 32'd3;
    @(negedge clk);
    chk("streamDrdy3", {31'd0, im_drdy}, 32'd1);
    chk("streamData3", im_data, 32'hA3);
    im_req = 1'b0;
    @(negedge clk);
    chk("streamIdle", {31'd0, im_drdy}, 32'd0);
    chk("streamHitCnt", hit_cnt, 32'd3);
    chk("streamMissCnt", miss_cnt, 32'd1);

    for (int i = 0; i < 10; i++) runVec(tbl[i]);

    // Flush on beat 2, then check that all lines were invalidated and that
    // the second refill marked its line valid.
    missFlush(32'h20, 32'h20, 2, 32'h80, 32'h90, 32'h90, 32'd8, 32'd8);
    runVec(mk(32'h0000_0002, 0, 32'h50, 0, 32'h52, 32'h0,  32'd8, 32'd9));
    runVec(mk(32'h0000_0020, 1, 32'h0,  0, 32'h90, 32'h0,  32'd9, 32'd9));

    // Flush on the same edge as the last beat: the flush wins.
    missFlush(32'h30, 32'h30, 3, 32'h70, 32'h78, 32'h78, 32'd9, 32'd11);
    runVec(mk(32'h0000_0020, 0, 32'h91, 0, 32'h91, 32'h20, 32'd9, 32'd12));

    // Asynchronous reset in the middle of a refill.
    @(negedge clk);
    im_req = 1'b1; im_addr = 32'h54;
    @(negedge clk);
    im_req = 1'b0;
    waitMemReq(ok);
    chk("rstSeqReq", {31'd0, ok}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h11 + b;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midRstDrdy", {31'd0, im_drdy}, 32'd0);
    chk("midRstData", im_data, 32'd0);
    chk("midRstMemReq", {31'd0, mem_req}, 32'd0);
    chk("midRstMemAddr", mem_addr, 32'd0);
    chk("midRstHitCnt", hit_cnt, 32'd0);
    chk("midRstMissCnt", miss_cnt, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_rvalid = 1'b0;
    chk("strayBeatMemReq", {31'd0, mem_req}, 32'd0);
    chk("strayBeatDrdy", {31'd0, im_drdy}, 32'd0);
    runVec(mk(32'h0000_0054, 0, 32'h60, 0, 32'h60, 32'h54, 32'd0, 32'd1));
    runVec(mk(32'h0000_0015, 0, 32'h65, 1, 32'h66, 32'h14, 32'd0, 32'd2));
    runVec(mk(32'h0000_0017, 1, 32'h0,  0, 32'h68, 32'h0,  32'd1, 32'd2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
